// File: rtl/btn_conditioner.sv
// Pushbutton conditioner: 2-flop synchronizer, debounce FSM and press/release pulses per channel.
// Optional auto-repeat on held buttons is enabled by defining BTN_AUTOREPEAT_EN.
module btn_conditioner #(
    parameter int unsigned N_BTN         = 3,
    parameter int unsigned DB_CYCLES     = 500000,
    parameter int unsigned CNT_W         = 20,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 5000000
) (
    input  logic             x1,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    // Reject configurations the counters cannot represent.
    if (DB_CYCLES < 2 || (64'(1) << CNT_W) <= 64'(DB_CYCLES)
        || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("btn_conditioner: illegal DB_CYCLES/CNT_W/REPEAT configuration");
    end

    logic [N_BTN-1:0] s1_q, s1_d, s2_q, s2_d;
    logic [N_BTN-1:0] level_q, level_d, press_q, press_d, release_q, release_d;
    state_e           state_q [N_BTN];
    state_e           state_d [N_BTN];
    logic [CNT_W-1:0] cnt_q   [N_BTN];
    logic [CNT_W-1:0] cnt_d   [N_BTN];

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = (RPT_MAX < 2) ? 1 : $clog2(RPT_MAX);
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_q [N_BTN];
    logic [RPT_W-1:0] rpt_d [N_BTN];
    // Set once the first repeat has fired; later repeats use the shorter period.
    logic [N_BTN-1:0] rep_q, rep_d;
`endif

    // Next-state and registered-output logic for all channels.
    always_comb begin
        s1_d      = btn_raw;
        s2_d      = s1_q;
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
`ifdef BTN_AUTOREPEAT_EN
        rep_d     = '0;
`endif
        for (int i = 0; i < int'(N_BTN); i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
`ifdef BTN_AUTOREPEAT_EN
            rpt_d[i]   = '0;
`endif
            case (state_q[i])
                ST_LOW: begin
                    if (s2_q[i]) begin
                        state_d[i] = ST_WAIT_HIGH;
                        cnt_d[i]   = CNT_W'(1);
                    end else begin
                        cnt_d[i] = '0;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (!s2_q[i]) begin
                        state_d[i] = ST_LOW;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == DB_LAST) begin
                        state_d[i] = ST_HIGH;
                        cnt_d[i]   = '0;
                        level_d[i] = 1'b1;
                        press_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (!s2_q[i]) begin
                        state_d[i] = ST_WAIT_LOW;
                        cnt_d[i]   = CNT_W'(1);
                    end else begin
                        cnt_d[i] = '0;
`ifdef BTN_AUTOREPEAT_EN
                        rep_d[i] = rep_q[i];
                        if (rpt_q[i] == (rep_q[i] ? RPT_PERIOD_LAST : RPT_DELAY_LAST)) begin
                            press_d[i] = 1'b1;
                            rep_d[i]   = 1'b1;
                        end else begin
                            rpt_d[i] = rpt_q[i] + RPT_W'(1);
                        end
`endif
                    end
                end
                ST_WAIT_LOW: begin
                    if (s2_q[i]) begin
                        state_d[i] = ST_HIGH;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == DB_LAST) begin
                        state_d[i]   = ST_LOW;
                        cnt_d[i]     = '0;
                        level_d[i]   = 1'b0;
                        release_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = ST_LOW;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge x1) begin
        if (reset) begin
            s1_q      <= '0;
            s2_q      <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < int'(N_BTN); i++) begin
                state_q[i] <= ST_LOW;
                cnt_q[i]   <= '0;
            end
`ifdef BTN_AUTOREPEAT_EN
            rep_q <= '0;
            for (int i = 0; i < int'(N_BTN); i++) begin
                rpt_q[i] <= '0;
            end
`endif
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < int'(N_BTN); i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
`ifdef BTN_AUTOREPEAT_EN
            rep_q <= rep_d;
            for (int i = 0; i < int'(N_BTN); i++) begin
                rpt_q[i] <= rpt_d[i];
            end
`endif
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule
